// File: rtl/gsensor_spi_reader_pkg.sv
// Shared constants for the ADXL345 SPI reader: register map, configuration
// values, command bits and the controller state encoding.
package gsensor_pkg;

  localparam logic [7:0] REG_BW_RATE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] CFG_DATA_FORMAT = 8'h08;
  localparam logic [7:0] CFG_BW_RATE     = 8'h0A;
  localparam logic [7:0] CFG_POWER_CTL   = 8'h08;

  localparam logic [7:0] CMD_R  = 8'h80;
  localparam logic [7:0] CMD_MB = 8'h40;
  localparam logic [7:0] RD_CMD = CMD_R | CMD_MB | REG_DATAX0;

  localparam int CFG_BYTES = 2;
  localparam int RD_BYTES  = 7;

  typedef enum logic [2:0] {
    PWR_WAIT    = 3'd0,
    CFG_XFER    = 3'd1,
    CFG_GAP     = 3'd2,
    SAMPLE_WAIT = 3'd3,
    RD_XFER     = 3'd4,
    RD_DONE     = 3'd5
  } state_e;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = {REG_DATA_FORMAT, CFG_DATA_FORMAT};
      2'd1:    cfg_word = {REG_BW_RATE, CFG_BW_RATE};
      2'd2:    cfg_word = {REG_POWER_CTL, CFG_POWER_CTL};
      default: cfg_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/gsensor_spi_reader_if.sv
// Accelerometer SPI pins plus the sample/status outputs of the reader.
interface gsensor_spi_reader_if;
  logic               o_gsensor_cs_n;
  logic               o_gsensor_sclk;
  logic               o_gsensor_sdi;
  logic               i_gsensor_sdo;
  logic signed [15:0] o_x;
  logic signed [15:0] o_y;
  logic signed [15:0] o_z;
  logic               o_valid;
  logic               o_init_done;
  logic               o_busy;

  modport master (
    output o_gsensor_cs_n, o_gsensor_sclk, o_gsensor_sdi,
    output o_x, o_y, o_z, o_valid, o_init_done, o_busy,
    input  i_gsensor_sdo
  );

  modport slave (
    input  o_gsensor_cs_n, o_gsensor_sclk, o_gsensor_sdi,
    input  o_x, o_y, o_z, o_valid, o_init_done, o_busy,
    output i_gsensor_sdo
  );
endinterface

// File: rtl/gsensor_spi_reader_shifter.sv
// Mode-3 SPI byte engine: one byte MSB first per start; o_done is asserted in the
// last cycle of the final high phase so a back-to-back start keeps SCLK periodic.
module spi_byte_shifter #(
  parameter int CLK_DIV = 25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic       i_sdo,
  output logic       o_sclk,
  output logic       o_sdi,
  output logic [7:0] o_rx,
  output logic       o_done
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          act_q, act_d, hi_q, hi_d, sclk_q, sclk_d, sdi_q, sdi_d;
  logic [7:0]    sh_q, sh_d, rx_q, rx_d;
  logic          half_end_s, last_s;

  assign half_end_s = (cnt_q == DW'(CLK_DIV - 1));
  assign last_s     = act_q & hi_q & half_end_s & (bit_q == 3'd7);

  // Half-period sequencing, shifting and MISO capture on the rising-edge cycle.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    act_d  = act_q;
    hi_d   = hi_q;
    sclk_d = sclk_q;
    sdi_d  = sdi_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (i_start && (!act_q || last_s)) begin
      act_d  = 1'b1;
      hi_d   = 1'b0;
      cnt_d  = '0;
      bit_d  = 3'd0;
      sclk_d = 1'b0;
      sdi_d  = i_tx[7];
      sh_d   = {i_tx[6:0], 1'b0};
    end else if (act_q) begin
      if (!half_end_s) begin
        cnt_d = cnt_q + DW'(1);
      end else if (!hi_q) begin
        cnt_d  = '0;
        hi_d   = 1'b1;
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], i_sdo};
      end else if (bit_q == 3'd7) begin
        cnt_d = '0;
        act_d = 1'b0;
        sdi_d = 1'b0;
      end else begin
        cnt_d  = '0;
        hi_d   = 1'b0;
        sclk_d = 1'b0;
        sdi_d  = sh_q[7];
        sh_d   = {sh_q[6:0], 1'b0};
        bit_d  = bit_q + 3'd1;
      end
    end else begin
      sclk_d = 1'b1;
      sdi_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      bit_q  <= 3'd0;
      act_q  <= 1'b0;
      hi_q   <= 1'b0;
      sclk_q <= 1'b1;
      sdi_q  <= 1'b0;
      sh_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      act_q  <= act_d;
      hi_q   <= hi_d;
      sclk_q <= sclk_d;
      sdi_q  <= sdi_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

  assign o_sclk = sclk_q;
  assign o_sdi  = sdi_q;
  assign o_rx   = rx_q;
  assign o_done = last_s;
endmodule

// File: rtl/gsensor_spi_reader.sv
// ADXL345 reader: power-up wait, three config writes, then periodic 6-byte burst
// reads of X/Y/Z. CS framing lives here; bit timing lives in spi_byte_shifter.
module gsensor_spi_reader
  import gsensor_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_TICKS  = 500000,
  parameter int POWERUP_TICKS = 100000
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  gsensor_spi_reader_if.master bus
);
  localparam int CW = $clog2(POWERUP_TICKS + 2 * CLK_DIV);
  localparam int PW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [2:0]    byte_q, byte_d;
  logic [1:0]    cfg_q, cfg_d;
  logic          act_q, act_d, per_en_q, per_en_d, cs_n_q, cs_n_d, busy_q, busy_d;
  logic          init_q, init_d, valid_q, valid_d;
  logic [47:0]   data_q, data_d;
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d, cfg_w_s;
  logic          start_s, done_s, last_s, expire_s;
  logic [7:0]    tx_s, rx_s;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(start_s),
    .i_tx   (tx_s),
    .i_sdo  (bus.i_gsensor_sdo),
    .o_sclk (bus.o_gsensor_sclk),
    .o_sdi  (bus.o_gsensor_sdi),
    .o_rx   (rx_s),
    .o_done (done_s)
  );

  // Sequencer: byte_q indexes the next byte to launch in the current frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    cfg_d    = cfg_q;
    act_d    = act_q;
    per_en_d = per_en_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    init_d   = init_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    start_s  = 1'b0;
    cfg_w_s  = cfg_word(cfg_q);
    if (state_q == CFG_XFER) begin
      tx_s   = (byte_q == 3'd0) ? cfg_w_s[15:8] : cfg_w_s[7:0];
      last_s = (byte_q == 3'(CFG_BYTES));
    end else begin
      tx_s   = (byte_q == 3'd0) ? RD_CMD : 8'h00;
      last_s = (byte_q == 3'(RD_BYTES));
    end
    // The sample period free-runs; an expiry outside SAMPLE_WAIT is simply lost.
    expire_s = per_en_q && (per_q == PW'(SAMPLE_TICKS - 1));
    if (!per_en_q || expire_s) begin
      per_d = '0;
    end else begin
      per_d = per_q + PW'(1);
    end
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CW'(POWERUP_TICKS - 1)) begin
          state_d = CFG_XFER;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          byte_d  = 3'd0;
          act_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CFG_XFER, RD_XFER: begin
        if (!act_q) begin
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            start_s = 1'b1;
            act_d   = 1'b1;
            byte_d  = byte_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (done_s) begin
          if (state_q == RD_XFER && byte_q >= 3'd2) begin
            data_d = {data_q[39:0], rx_s};
          end else begin
            data_d = data_q;
          end
          if (last_s) begin
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            act_d   = 1'b0;
            cnt_d   = '0;
            state_d = (state_q == CFG_XFER) ? CFG_GAP : RD_DONE;
          end else begin
            start_s = 1'b1;
            byte_d  = byte_q + 3'd1;
          end
        end else begin
          act_d = act_q;
        end
      end
      CFG_GAP: begin
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          if (cfg_q == 2'd2) begin
            init_d   = 1'b1;
            per_en_d = 1'b1;
            state_d  = SAMPLE_WAIT;
          end else begin
            cfg_d   = cfg_q + 2'd1;
            state_d = CFG_XFER;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            byte_d  = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE_WAIT: begin
        if (expire_s) begin
          state_d = RD_XFER;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          byte_d  = 3'd0;
          act_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = SAMPLE_WAIT;
        end
      end
      RD_DONE: begin
        x_d     = {data_q[39:32], data_q[47:40]};
        y_d     = {data_q[23:16], data_q[31:24]};
        z_d     = {data_q[7:0],   data_q[15:8]};
        valid_d = 1'b1;
        state_d = SAMPLE_WAIT;
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= PWR_WAIT;
      cnt_q    <= '0;
      per_q    <= '0;
      byte_q   <= 3'd0;
      cfg_q    <= 2'd0;
      act_q    <= 1'b0;
      per_en_q <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      init_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 48'h0;
      x_q      <= 16'h0000;
      y_q      <= 16'h0000;
      z_q      <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      byte_q   <= byte_d;
      cfg_q    <= cfg_d;
      act_q    <= act_d;
      per_en_q <= per_en_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      init_q   <= init_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
    end
  end

  assign bus.o_gsensor_cs_n = cs_n_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_init_done    = init_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_x            = x_q;
  assign bus.o_y            = y_q;
  assign bus.o_z            = z_q;
endmodule

// File: tb/tb_gsensor_spi_reader.sv
// Two readers (long and short sample period) against a bit-level ADXL345 model
// that logs every CS frame and predicts each X/Y/Z sample from the bytes it sent.
module tb_gsensor_spi_reader;
  localparam int CD   = 3;
  localparam int PU   = 40;
  localparam int ST_A = 1000;
  localparam int ST_B = 200;
  localparam int NF   = 64;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  initial forever #5 clk = ~clk;

  gsensor_spi_reader_if bus_a ();
  gsensor_spi_reader_if bus_b ();

  gsensor_spi_reader #(.CLK_DIV(CD), .SAMPLE_TICKS(ST_A), .POWERUP_TICKS(PU)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .bus(bus_a));
  gsensor_spi_reader #(.CLK_DIV(CD), .SAMPLE_TICKS(ST_B), .POWERUP_TICKS(PU)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .bus(bus_b));

  logic        cs [2], sclk [2], sdi [2], vld [2], sdo_m [2];
  logic [15:0] ox [2], oy [2], oz [2];
  assign cs[0] = bus_a.o_gsensor_cs_n;  assign cs[1] = bus_b.o_gsensor_cs_n;
  assign sclk[0] = bus_a.o_gsensor_sclk; assign sclk[1] = bus_b.o_gsensor_sclk;
  assign sdi[0] = bus_a.o_gsensor_sdi;  assign sdi[1] = bus_b.o_gsensor_sdi;
  assign vld[0] = bus_a.o_valid;        assign vld[1] = bus_b.o_valid;
  assign ox[0] = bus_a.o_x; assign oy[0] = bus_a.o_y; assign oz[0] = bus_a.o_z;
  assign ox[1] = bus_b.o_x; assign oy[1] = bus_b.o_y; assign oz[1] = bus_b.o_z;
  assign bus_a.i_gsensor_sdo = sdo_m[0];
  assign bus_b.i_gsensor_sdo = sdo_m[1];

  int          cyc;
  logic        pcs [2], psclk [2], pvld [2], tok [2], first_fall [2];
  int          t_cs [2], t_rise [2], bits [2];
  logic [55:0] acc [2];
  logic [7:0]  resp [2][6];
  logic [55:0] fr_data [2][NF];
  int          fr_bits [2][NF], fr_t0 [2][NF], fr_n [2];
  logic        fr_ok [2][NF];
  logic [47:0] exp_s [2][NF], got_s [2][NF];
  int          exp_n [2], v_cyc [2][NF], v_fr [2][NF], v_n [2], vwide [2], idle_err [2], rd_n [2];

  int n_cmp, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sensor model and frame logger, sampled on the falling system-clock edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      pcs[d] = 1'b1; psclk[d] = 1'b1; pvld[d] = 1'b0; sdo_m[d] = 1'b0;
      fr_n[d] = 0; exp_n[d] = 0; v_n[d] = 0; vwide[d] = 0; idle_err[d] = 0; rd_n[d] = 0;
      bits[d] = 0; t_cs[d] = 0; t_rise[d] = 0; tok[d] = 1'b0; first_fall[d] = 1'b0; acc[d] = '0;
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (pcs[d] && !cs[d]) begin
          bits[d] = 0; acc[d] = '0; tok[d] = 1'b1; first_fall[d] = 1'b1; t_cs[d] = cyc;
          for (int i = 0; i < 6; i++) resp[d][i] = 8'($urandom);
          if (d == 0 && fr_n[0] == 3) begin
            resp[0][0] = 8'h34; resp[0][1] = 8'h12; resp[0][2] = 8'hCC;
            resp[0][3] = 8'hFF; resp[0][4] = 8'h00; resp[0][5] = 8'h40;
          end
        end
        if (!cs[d] && psclk[d] && !sclk[d]) begin
          if (first_fall[d] && (cyc - t_cs[d] != CD)) tok[d] = 1'b0;
          first_fall[d] = 1'b0;
          if (bits[d] >= 8 && bits[d] < 56) sdo_m[d] = resp[d][bits[d] / 8 - 1][7 - bits[d] % 8];
          else sdo_m[d] = 1'b0;
        end
        if (!cs[d] && !psclk[d] && sclk[d]) begin
          if (bits[d] > 0 && (cyc - t_rise[d] != 2 * CD)) tok[d] = 1'b0;
          t_rise[d] = cyc;
          acc[d] = {acc[d][54:0], sdi[d]};
          bits[d]++;
        end
        if (!pcs[d] && cs[d]) begin
          if (cyc - t_rise[d] != CD) tok[d] = 1'b0;
          if (fr_n[d] < NF) begin
            fr_data[d][fr_n[d]] = acc[d]; fr_bits[d][fr_n[d]] = bits[d];
            fr_ok[d][fr_n[d]] = tok[d]; fr_t0[d][fr_n[d]] = t_cs[d];
            fr_n[d]++;
          end
          if (bits[d] == 56) begin
            rd_n[d]++;
            if (exp_n[d] < NF) begin
              exp_s[d][exp_n[d]] = {resp[d][1], resp[d][0], resp[d][3], resp[d][2], resp[d][5], resp[d][4]};
              exp_n[d]++;
            end
          end
          sdo_m[d] = 1'b0;
        end
        if (cs[d] && (!sclk[d] || sdi[d])) idle_err[d]++;
        if (vld[d]) begin
          if (pvld[d]) vwide[d]++;
          else if (v_n[d] < NF) begin
            got_s[d][v_n[d]] = {ox[d], oy[d], oz[d]};
            v_cyc[d][v_n[d]] = cyc; v_fr[d][v_n[d]] = rd_n[d];
            v_n[d]++;
          end
        end
        pcs[d] = cs[d]; psclk[d] = sclk[d]; pvld[d] = vld[d];
      end
    end
  end

  logic [15:0] cfg_exp [3];
  int c_rel, fr_before, bad;

  initial begin
    n_cmp = 0; n_fail = 0;
    cfg_exp[0] = 16'h3108; cfg_exp[1] = 16'h2C0A; cfg_exp[2] = 16'h2D08;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(bus_a.o_gsensor_cs_n), 64'd1);
    chk("rst_sclk", 64'(bus_a.o_gsensor_sclk), 64'd1);
    chk("rst_sdi", 64'(bus_a.o_gsensor_sdi), 64'd0);
    chk("rst_flags", 64'({bus_a.o_valid, bus_a.o_init_done, bus_a.o_busy}), 64'd0);
    chk("rst_xyz", 64'({bus_a.o_x, bus_a.o_y, bus_a.o_z}), 64'd0);

    @(negedge clk); #2;
    rst_a_n = 1'b1; rst_b_n = 1'b1; c_rel = cyc;
    for (int i = 0; i < 3000; i++) begin
      if (bus_a.o_init_done) break;
      @(posedge clk); #1;
    end
    chk("init_done", 64'(bus_a.o_init_done), 64'd1);
    chk("cfg_frames", 64'(fr_n[0]), 64'd3);
    chk("powerup_wait", 64'(fr_t0[0][0] - c_rel), 64'(PU));
    for (int k = 0; k < 3; k++) begin
      chk("cfg_bits", 64'(fr_bits[0][k]), 64'd16);
      chk("cfg_word", 64'(fr_data[0][k][15:0]), 64'(cfg_exp[k]));
      chk("cfg_timing", 64'(fr_ok[0][k]), 64'd1);
    end

    // Ten expiries plus one read latency.
    repeat (10700) @(posedge clk);
    #1;
    chk("valid_count_a", 64'(v_n[0]), 64'd10);
    chk("sample_x", 64'(got_s[0][0][47:32]), 64'h1234);
    chk("sample_y", 64'(got_s[0][0][31:16]), 64'hFFCC);
    chk("sample_z", 64'(got_s[0][0][15:0]), 64'h4000);
    for (int k = 0; k < v_n[0]; k++) chk("sample_a", 64'(got_s[0][k]), 64'(exp_s[0][k]));
    for (int k = 1; k < v_n[0]; k++) chk("spacing_a", 64'(v_cyc[0][k] - v_cyc[0][k-1]), 64'(ST_A));
    chk("valid_width_a", 64'(vwide[0]), 64'd0);
    for (int k = 3; k < fr_n[0]; k++) begin
      chk("rd_bits", 64'(fr_bits[0][k]), 64'd56);
      chk("rd_cmd", 64'(fr_data[0][k][55:48]), 64'hF2);
      chk("rd_dummy", 64'(fr_data[0][k][47:0]), 64'd0);
      chk("rd_timing", 64'(fr_ok[0][k]), 64'd1);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if (!bus_a.o_gsensor_cs_n && bits[0] >= 20) break;
    end
    chk("byte3_reached", 64'(bits[0] >= 20 && bits[0] < 24), 64'd1);
    fr_before = fr_n[0];
    rst_a_n = 1'b0;
    #1;
    chk("mid_rst_cs_sclk", 64'({bus_a.o_gsensor_cs_n, bus_a.o_gsensor_sclk, bus_a.o_gsensor_sdi}), 64'b110);
    chk("mid_rst_xyz", 64'({bus_a.o_x, bus_a.o_y, bus_a.o_z}), 64'd0);
    chk("mid_rst_flags", 64'({bus_a.o_valid, bus_a.o_init_done, bus_a.o_busy}), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst_a_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bus_a.o_init_done) break;
      @(posedge clk); #1;
    end
    chk("reinit_done", 64'(bus_a.o_init_done), 64'd1);
    chk("reinit_frames", 64'(fr_n[0] - fr_before), 64'd4);
    for (int k = 0; k < 3; k++) begin
      chk("recfg_word", 64'(fr_data[0][fr_before + 1 + k][15:0]), 64'(cfg_exp[k]));
      chk("recfg_bits", 64'(fr_bits[0][fr_before + 1 + k]), 64'd16);
    end

    chk("valid_count_b_min", 64'(v_n[1] >= 20), 64'd1);
    bad = 0;
    for (int k = 0; k < v_n[1]; k++) begin
      chk("sample_b", 64'(got_s[1][k]), 64'(exp_s[1][k]));
      chk("frame_before_valid_b", 64'(v_fr[1][k]), 64'(k + 1));
      if (k > 0) chk("spacing_b", 64'(v_cyc[1][k] - v_cyc[1][k-1]), 64'(2 * ST_B));
    end
    for (int k = 3; k < fr_n[1]; k++) if (fr_bits[1][k] != 56 || !fr_ok[1][k]) bad++;
    chk("frames_b", 64'(bad), 64'd0);
    chk("valid_width_b", 64'(vwide[1]), 64'd0);
    chk("idle_lines", 64'(idle_err[0] + idle_err[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
